// File: rtl/fwd_stall_unit.sv
// Operand forwarding and load-use interlock beside the IDU: per-port bypass
// muxes resolved EXE > MEM > WB > regfile, a load-latency stall FSM and a stall counter.

module fwd_port #(
  parameter int XLEN = 32
) (
  input  logic            id_valid,
  input  logic            used,
  input  logic [4:0]      addr,
  input  logic [XLEN-1:0] rf_rdata,
  input  logic            exe_valid,
  input  logic            exe_wen,
  input  logic [4:0]      exe_rd,
  input  logic [XLEN-1:0] exe_res,
  input  logic            mem_valid,
  input  logic            mem_wen,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_res,
  input  logic            wb_valid,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] rs_data,
  output logic [1:0]      fwd_sel,
  output logic            m_exe,
  output logic            m_mem
);
  logic live, m_wb;

  // x0 never forwards; an unread port never matches, so it cannot stall either
  assign live  = id_valid & used & (addr != 5'd0);
  assign m_exe = live & exe_valid & exe_wen & (addr == exe_rd);
  assign m_mem = live & mem_valid & mem_wen & (addr == mem_rd);
  assign m_wb  = live & wb_valid  & wb_wen  & (addr == wb_rd);

  always_comb begin
    rs_data = rf_rdata;
    fwd_sel = 2'd0;
    if (m_exe) begin
      rs_data = exe_res;
      fwd_sel = 2'd3;
    end else if (m_mem) begin
      rs_data = mem_res;
      fwd_sel = 2'd2;
    end else if (m_wb) begin
      rs_data = wb_data;
      fwd_sel = 2'd1;
    end
  end
endmodule

module fwd_stall_unit #(
  parameter int XLEN     = 32,
  parameter int NRP      = 2,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [NRP-1:0][4:0]       id_rs_addr,
  input  logic [NRP-1:0]            id_rs_used,
  input  logic [NRP-1:0][XLEN-1:0]  rf_rdata,
  input  logic                      exe_valid,
  input  logic                      mem_valid,
  input  logic                      wb_valid,
  input  logic                      exe_wen,
  input  logic                      mem_wen,
  input  logic                      wb_wen,
  input  logic                      exe_load,
  input  logic                      mem_load,
  input  logic [4:0]                exe_rd,
  input  logic [4:0]                mem_rd,
  input  logic [4:0]                wb_rd,
  input  logic [XLEN-1:0]           exe_res,
  input  logic [XLEN-1:0]           mem_res,
  input  logic [XLEN-1:0]           wb_data,
  output logic [NRP-1:0][XLEN-1:0]  rs_data,
  output logic [NRP-1:0][1:0]       fwd_sel,
  output logic                      ready_go,
  output logic [CNT_W-1:0]          stall_cnt,
  input  logic                      stall_cnt_clr
);
  localparam logic [1:0] N_EXE = 2'(LOAD_LAT);
  localparam logic [1:0] N_MEM = 2'(LOAD_LAT - 1);

  typedef enum logic {IDLE, STALL} state_t;

  state_t         state;
  logic [1:0]     cnt;
  logic [1:0]     n_dem;
  logic [NRP-1:0] m_exe, m_mem;

  for (genvar i = 0; i < NRP; i++) begin : g_port
    fwd_port #(.XLEN(XLEN)) u_port (
      .id_valid (id_valid),
      .used     (id_rs_used[i]),
      .addr     (id_rs_addr[i]),
      .rf_rdata (rf_rdata[i]),
      .exe_valid(exe_valid),
      .exe_wen  (exe_wen),
      .exe_rd   (exe_rd),
      .exe_res  (exe_res),
      .mem_valid(mem_valid),
      .mem_wen  (mem_wen),
      .mem_rd   (mem_rd),
      .mem_res  (mem_res),
      .wb_valid (wb_valid),
      .wb_wen   (wb_wen),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .rs_data  (rs_data[i]),
      .fwd_sel  (fwd_sel[i]),
      .m_exe    (m_exe[i]),
      .m_mem    (m_mem[i])
    );
  end

  // Older load in MEM needs one cycle less; the EXE load always dominates
  always_comb begin
    n_dem = 2'd0;
    if (|(m_exe & {NRP{exe_load}}))
      n_dem = N_EXE;
    else if (|(m_mem & {NRP{mem_load}}))
      n_dem = N_MEM;
  end

  always_comb begin
    ready_go = 1'b1;
    if (!flush)
      ready_go = (state == IDLE) ? (n_dem == 2'd0) : (cnt == 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      case (state)
        IDLE:
          if (n_dem != 2'd0) begin
            state <= STALL;
            cnt   <= n_dem - 2'd1;
          end
        STALL:
          if (cnt != 2'd0) cnt <= cnt - 2'd1;
          else             state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall_cnt_clr)
      stall_cnt <= '0;
    else if (!ready_go && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end
endmodule
